// File: rtl/bpsk_pkg.sv
// bpsk_pkg: constants, accumulator sizing and FSM states shared by the BPSK modulator and demodulator
package bpsk_pkg;
  localparam int NBITS = 64;
  localparam int SPB = 1000;
  localparam int CPER = 10;
  localparam int SW = 9;
  function automatic int accw(input int sw, input int spb);
    return sw + $clog2(spb) + 1;
  endfunction
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bpsk_correlator.sv
// bpsk_correlator: integrate-and-dump of samples against a +/-1 square reference
module bpsk_correlator import bpsk_pkg::*; #(
  parameter int SW = bpsk_pkg::SW,
  parameter int ACCW = accw(bpsk_pkg::SW, SPB)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic signed [SW-1:0]   sample_in,
  input  logic                   sample_valid,
  input  logic                   ref_sign,
  output logic signed [ACCW-1:0] acc,
  output logic signed [ACCW-1:0] acc_nxt
);
  logic signed [ACCW-1:0] s;
  always_comb begin
    s = ACCW'(sample_in);
    acc_nxt = !sample_valid ? acc : ref_sign ? acc + s : acc - s;
  end
  always_ff @(posedge clk)
    acc <= (reset || clear) ? '0 : acc_nxt;
endmodule

// File: rtl/bpsk_demod_deser.sv
// bpsk_demod_deser: correlates BPSK samples per bit period, slices bits and rebuilds the frame MSB first
module bpsk_demod_deser import bpsk_pkg::*; #(
  parameter int NBITS = bpsk_pkg::NBITS,
  parameter int SPB = bpsk_pkg::SPB,
  parameter int CPER = bpsk_pkg::CPER,
  parameter int SW = bpsk_pkg::SW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [SW-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic [NBITS-1:0]     data_out,
  output logic                 done,
  output logic                 busy
);
  localparam int ACCW = accw(SW, SPB);
  localparam int SCW = $clog2(SPB);
  localparam int PW = $clog2(CPER);
  localparam int BW = $clog2(NBITS);
  localparam logic [SCW-1:0] S_LAST = SCW'(SPB - 1);
  localparam logic [PW-1:0] P_LAST = PW'(CPER - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CPER / 2);
  localparam logic [BW-1:0] B_LAST = BW'(NBITS - 1);
  state_t state, state_nxt;
  logic [SCW-1:0] sample_cnt;
  logic [PW-1:0] carrier_phase;
  logic [BW-1:0] bit_cnt;
  logic [NBITS-2:0] shreg;
  logic signed [ACCW-1:0] acc_unused, acc_nxt;
  logic arm, take, dec, last, bit_d;
  bpsk_correlator #(.SW(SW), .ACCW(ACCW)) u_corr (
    .clk(clk), .reset(reset), .clear(arm || dec), .sample_in(sample_in),
    .sample_valid(take), .ref_sign(carrier_phase < P_HALF),
    .acc(acc_unused), .acc_nxt(acc_nxt)
  );
  // start is honoured in IDLE and in DONE, which gives back-to-back frames
  always_comb begin
    arm = start && state != RUN;
    take = state == RUN && sample_valid;
    dec = take && sample_cnt == S_LAST;
    last = dec && bit_cnt == B_LAST;
    bit_d = !acc_nxt[ACCW-1];
    state_nxt = arm ? RUN : last ? DONE : state == DONE ? IDLE : state;
    busy = state == RUN;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_cnt <= '0;
      carrier_phase <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      done <= 1'b0;
      data_out <= '0;
    end else begin
      bit_valid <= dec;
      done <= last;
      if (arm) begin
        sample_cnt <= '0;
        carrier_phase <= '0;
        bit_cnt <= '0;
      end else if (take) begin
        carrier_phase <= carrier_phase == P_LAST ? '0 : carrier_phase + 1'b1;
        sample_cnt <= dec ? '0 : sample_cnt + 1'b1;
      end
      if (dec) begin
        bit_out <= bit_d;
        shreg <= {shreg[NBITS-3:0], bit_d};
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;
      end
      if (last)
        data_out <= {shreg, bit_d};
    end
  end
endmodule
